// File: rtl/run_sequencer.sv
// run_sequencer: sequences a single program run of the 9-bit-ISA core.
// The block owns the core's reset and run-enable. It turns the bench-level
// start handshake into a clean run. The run ends on a halt instruction, on a
// PC stall (optional), or on a watchdog timeout. All outputs are registered.
// Optional feature: define RUN_SEQ_PC_STALL_EN to treat STALL_CYCLES
// consecutive unchanged-PC RUN cycles as a halt.
module run_sequencer #(
  parameter int PC_W         = 7,
  parameter int CNT_W        = 10,
  parameter int TIMEOUT      = 1000,
  parameter int STALL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic [PC_W-1:0]  pc,
  output logic             core_reset,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               start_q_r;
  logic               start_rise_s;
  logic               start_fall_s;
  logic               timeout_hit_s;
  logic               stall_hit_s;

  logic               core_reset_r;
  logic               run_en_r;
  logic               busy_r;
  logic               done_r;
  logic               timeout_r;
  logic [CNT_W-1:0]   cycle_count_r;

  logic               core_reset_s;
  logic               run_en_s;
  logic               busy_s;
  logic               done_s;
  logic               timeout_s;
  logic [CNT_W-1:0]   cycle_count_s;

  assign start_rise_s  = ~start_q_r & start;
  assign start_fall_s  = start_q_r & ~start;
  // Count starts at 0 in the first RUN cycle, so the last allowed cycle is TIMEOUT-1.
  assign timeout_hit_s = (cycle_count_r == CNT_W'(TIMEOUT - 1));

`ifdef RUN_SEQ_PC_STALL_EN
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  logic [PC_W-1:0]    prev_pc_r;
  logic               prev_valid_r;
  logic [STALL_W-1:0] stall_cnt_r;
  logic               pc_same_s;

  // The first RUN cycle has no valid previous PC, so it never counts as a repeat.
  assign pc_same_s   = prev_valid_r & (pc == prev_pc_r);
  // This repeat brings the streak up to STALL_CYCLES.
  assign stall_hit_s = pc_same_s & (stall_cnt_r == STALL_LAST);

  // Track the previous RUN-cycle PC and the length of the current unchanged-PC streak.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc_r    <= '0;
      prev_valid_r <= 1'b0;
      stall_cnt_r  <= '0;
    end else if (state_s == ST_ARM) begin
      prev_pc_r    <= '0;
      prev_valid_r <= 1'b0;
      stall_cnt_r  <= '0;
    end else if (state_r == ST_RUN) begin
      prev_pc_r    <= pc;
      prev_valid_r <= 1'b1;
      if (pc_same_s) begin
        if (stall_cnt_r != {STALL_W{1'b1}}) begin
          stall_cnt_r <= stall_cnt_r + STALL_W'(1);
        end else begin
          stall_cnt_r <= stall_cnt_r;
        end
      end else begin
        stall_cnt_r <= '0;
      end
    end else begin
      prev_pc_r    <= prev_pc_r;
      prev_valid_r <= prev_valid_r;
      stall_cnt_r  <= stall_cnt_r;
    end
  end
`else
  // pc and STALL_CYCLES only feed stall detection. Fold them into a sink so
  // the disabled build has no dangling inputs.
  logic unused_stall_cfg_s;
  assign unused_stall_cfg_s = ^{pc, 32'(STALL_CYCLES)};
  assign stall_hit_s        = 1'b0;
`endif

  // State, start history and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      start_q_r     <= 1'b0;
      core_reset_r  <= 1'b1;
      run_en_r      <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      timeout_r     <= 1'b0;
      cycle_count_r <= '0;
    end else begin
      state_r       <= state_s;
      start_q_r     <= start;
      core_reset_r  <= core_reset_s;
      run_en_r      <= run_en_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      timeout_r     <= timeout_s;
      cycle_count_r <= cycle_count_s;
    end
  end

  // Next-state selection. RUN exits in priority order: abort, halt, stall, watchdog.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_ARM;
        else       state_s = ST_IDLE;
      end
      ST_ARM: begin
        if (start_fall_s) state_s = ST_RUN;
        else              state_s = ST_ARM;
      end
      ST_RUN: begin
        if (start_rise_s)       state_s = ST_ARM;
        else if (halt)          state_s = ST_DONE;
        else if (stall_hit_s)   state_s = ST_DONE;
        else if (timeout_hit_s) state_s = ST_DONE;
        else                    state_s = ST_RUN;
      end
      ST_DONE: begin
        if (start_rise_s) state_s = ST_ARM;
        else              state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output values for the state being entered. They are registered alongside it.
  always_comb begin
    core_reset_s  = 1'b1;
    run_en_s      = 1'b0;
    busy_s        = 1'b0;
    done_s        = 1'b0;
    timeout_s     = 1'b0;
    cycle_count_s = cycle_count_r;
    case (state_s)
      ST_IDLE: begin
        cycle_count_s = '0;
      end
      ST_ARM: begin
        cycle_count_s = '0;
      end
      ST_RUN: begin
        core_reset_s = 1'b0;
        run_en_s     = 1'b1;
        busy_s       = 1'b1;
        if (state_r == ST_RUN) cycle_count_s = cycle_count_r + CNT_W'(1);
        else                   cycle_count_s = '0;
      end
      ST_DONE: begin
        // Keep the core out of reset so its regfile and memory can be inspected.
        core_reset_s = 1'b0;
        done_s       = 1'b1;
        // A halt or stall in the same cycle as the watchdog takes precedence.
        if (state_r == ST_RUN) timeout_s = timeout_hit_s & ~halt & ~stall_hit_s;
        else                   timeout_s = timeout_r;
      end
      default: begin
        cycle_count_s = '0;
      end
    endcase
  end

  assign core_reset  = core_reset_r;
  assign run_en      = run_en_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign timeout     = timeout_r;
  assign cycle_count = cycle_count_r;

endmodule
